// File: rtl/first_counter.sv
// Synchronous up-counter with count enable and a registered one-cycle wrap strobe.
// Both outputs come straight from flops, so no input reaches an output combinationally.
module first_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // The strobe is rewritten on every edge, so it can never stay high for more than one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out  <= '0;
      overflow_out <= 1'b0;
    end else if (enable) begin
      if (counter_out == MAX) begin
        counter_out  <= '0;
        overflow_out <= 1'b1;
      end else begin
        counter_out  <= counter_out + ONE;
        overflow_out <= 1'b0;
      end
    end else begin
      overflow_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_first_counter.sv
// Directed bench for first_counter: reset, count, hold, wrap, gated-at-max and mid-count reset.
// Inputs change on the falling edge; outputs are checked 1 ns after each rising edge.
module tb_first_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] counter_out;
  logic             overflow_out;

  int checks;
  int errors;

  first_counter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .counter_out  (counter_out),
    .overflow_out (overflow_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // one clock: apply inputs, take the edge, compare both outputs
  task automatic step(input string tag, input logic rst_v, input logic en_v,
                      input int exp_cnt, input logic exp_ovf);
    @(negedge clk);
    reset  = rst_v;
    enable = en_v;
    @(posedge clk);
    #1;
    check({tag, ".cnt"}, 32'(counter_out), 32'(exp_cnt));
    check({tag, ".ovf"}, 32'(overflow_out), 32'(exp_ovf));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    enable = 1'b0;

    // reset, including reset dominating enable
    step("rst0", 1'b1, 1'b0, 0, 1'b0);
    step("rst1", 1'b1, 1'b1, 0, 1'b0);

    // count 1..5
    for (int i = 1; i <= 5; i++) step("count", 1'b0, 1'b1, i, 1'b0);

    // hold at 5, then resume
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 5, 1'b0);
    step("resume", 1'b0, 1'b1, 6, 1'b0);

    // wrap from 0: pulse at the 16th edge and again 16 edges later
    step("wrap_rst", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 15; i++) step("wrap_up", 1'b0, 1'b1, i, 1'b0);
    step("wrap_pulse1", 1'b0, 1'b1, 0, 1'b1);
    for (int i = 1; i <= 15; i++) step("wrap_up2", 1'b0, 1'b1, i, 1'b0);
    step("wrap_pulse2", 1'b0, 1'b1, 0, 1'b1);
    step("wrap_after", 1'b0, 1'b1, 1, 1'b0);

    // gated at max: hold 15 without a strobe, then wrap
    step("gate_rst", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 15; i++) step("gate_up", 1'b0, 1'b1, i, 1'b0);
    step("gate_hold0", 1'b0, 1'b0, 15, 1'b0);
    step("gate_hold1", 1'b0, 1'b0, 15, 1'b0);
    step("gate_wrap", 1'b0, 1'b1, 0, 1'b1);
    step("gate_clear", 1'b0, 1'b0, 0, 1'b0);

    // reset mid-count at 9, then resume
    step("mid_rst", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 9; i++) step("mid_up", 1'b0, 1'b1, i, 1'b0);
    step("mid_reset", 1'b1, 1'b1, 0, 1'b0);
    step("mid_resume1", 1'b0, 1'b1, 1, 1'b0);
    step("mid_resume2", 1'b0, 1'b1, 2, 1'b0);

    // reset at 15 with enable: no strobe
    for (int i = 3; i <= 15; i++) step("max_up", 1'b0, 1'b1, i, 1'b0);
    step("max_reset", 1'b1, 1'b1, 0, 1'b0);
    step("max_after", 1'b0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
